// File: rtl/npu_mem_responder_if.sv
// Bus bundle between the CPU/NPU side and the memory responder.
// master: CPU data-memory port plus NPU engine (drives requests).
// slave : the responder (drives load data, hazard and NPU handshake).
interface npu_mem_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // CPU data-memory interface
    logic              memread_c;
    logic              memwrite_c;
    logic [31:0]       addr_c;
    logic [DATA_W-1:0] wd_c;
    logic [DATA_W-1:0] R_DATA;
    logic              mem_haz;

    // CPU -> NPU handshake
    logic              EN_NPU;
    logic [ADDR_W-1:0] matA;
    logic [ADDR_W-1:0] matB;
    logic [ADDR_W-1:0] matC;
    logic              acquire_npu;

    // NPU engine control
    logic              npu_start;
    logic [ADDR_W-1:0] npu_base_a;
    logic [ADDR_W-1:0] npu_base_b;
    logic [ADDR_W-1:0] npu_base_c;
    logic              npu_done;
    logic              npu_err;

    // NPU engine array access
    logic              npu_rd_en;
    logic [ADDR_W-1:0] npu_rd_addr;
    logic [DATA_W-1:0] npu_rd_data;
    logic              npu_wr_en;
    logic [ADDR_W-1:0] npu_wr_addr;
    logic [DATA_W-1:0] npu_wr_data;

    modport master (
        output memread_c, memwrite_c, addr_c, wd_c,
        input  R_DATA, mem_haz,
        output EN_NPU, matA, matB, matC,
        input  acquire_npu,
        input  npu_start, npu_base_a, npu_base_b, npu_base_c, npu_err,
        output npu_done,
        output npu_rd_en, npu_rd_addr,
        input  npu_rd_data,
        output npu_wr_en, npu_wr_addr, npu_wr_data
    );

    modport slave (
        input  memread_c, memwrite_c, addr_c, wd_c,
        output R_DATA, mem_haz,
        input  EN_NPU, matA, matB, matC,
        output acquire_npu,
        output npu_start, npu_base_a, npu_base_b, npu_base_c, npu_err,
        input  npu_done,
        input  npu_rd_en, npu_rd_addr,
        output npu_rd_data,
        input  npu_wr_en, npu_wr_addr, npu_wr_data
    );
endinterface

// File: rtl/npu_mem_responder.sv
// Memory-side responder: owns the DEPTH x DATA_W data array shared by the
// CPU and the NPU engine, arbitrates ownership (CPU in IDLE/ACK, NPU in
// LAUNCH/RUN), runs the two-phase CPU load protocol and sequences NPU
// launch/completion with a RUN watchdog. DEPTH must equal 2**ADDR_W.
module npu_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int TIMEOUT = 4096
) (
    input logic                clk,
    input logic                rst,
    npu_mem_responder_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        ACK
    } state_t;

    state_t state;

    // Data array (not reset)
    logic [DATA_W-1:0] mem [DEPTH];

    // CPU load tracking
    logic              rd_phase;
    logic [ADDR_W-1:0] rd_idx_q;

    // Registered outputs
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] npu_rd_data_q;
    logic              acquire_q;
    logic              start_q;
    logic              err_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] base_c_q;
    logic [CNT_W-1:0]  cnt;

    // Decoded CPU request
    logic              cpu_own;
    logic [ADDR_W-1:0] cpu_idx;
    logic              cpu_oor;
    logic              cpu_wr;
    logic              cpu_rd;
    logic              rd_hit;
    logic              launch_ok;

    // Array port controls
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;

    // Byte offset within a word carries no meaning here
    logic unused_byte_bits;
    assign unused_byte_bits = &{1'b0, bus.addr_c[1:0]};

    assign cpu_own   = (state == IDLE) || (state == ACK);
    assign cpu_idx   = bus.addr_c[ADDR_W+1:2];
    assign cpu_oor   = |bus.addr_c[31:ADDR_W+2];
    assign cpu_wr    = cpu_own && bus.memwrite_c;
    // A simultaneous store wins; the load is ignored entirely
    assign cpu_rd    = cpu_own && bus.memread_c && !bus.memwrite_c;
    // Second phase of a load to the same word completes it
    assign rd_hit    = cpu_rd && rd_phase && (cpu_idx == rd_idx_q);
    // Launch waits for any in-flight load phase and any store this cycle
    assign launch_ok = (state == IDLE) && bus.EN_NPU && !rd_phase && !bus.memwrite_c;

    // Hazard: loads stall for their first phase; while the NPU owns the
    // array every CPU request stalls. Held low during reset.
    always_comb begin
        bus.mem_haz = 1'b0;
        if (rst) begin
            if (cpu_own) begin
                bus.mem_haz = cpu_rd && !rd_hit;
            end else begin
                bus.mem_haz = bus.memread_c || bus.memwrite_c;
            end
        end
    end

    // Select the single write port's source by current owner
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (cpu_own) begin
            wr_en   = cpu_wr && !cpu_oor;
            wr_addr = cpu_idx;
            wr_data = bus.wd_c;
        end else begin
            wr_en   = bus.npu_wr_en;
            wr_addr = bus.npu_wr_addr;
            wr_data = bus.npu_wr_data;
        end
    end

    assign rd_addr = cpu_own ? cpu_idx : bus.npu_rd_addr;
    assign rd_word = mem[rd_addr];

    // Array write port; a same-address read in this cycle sees old data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, steered to the CPU or NPU result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_q      <= '0;
            npu_rd_data_q <= '0;
        end else begin
            if (rd_hit) begin
                r_data_q <= cpu_oor ? '0 : rd_word;
            end
            if (!cpu_own && bus.npu_rd_en) begin
                npu_rd_data_q <= rd_word;
            end
        end
    end

    // CPU load phase tracking; a dropped or re-targeted load restarts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_phase <= 1'b0;
            rd_idx_q <= '0;
        end else if (!cpu_own) begin
            rd_phase <= 1'b0;
        end else if (cpu_rd && !rd_hit) begin
            rd_phase <= 1'b1;
            rd_idx_q <= cpu_idx;
        end else begin
            rd_phase <= 1'b0;
        end
    end

    // Ownership / NPU sequencing FSM with registered handshake outputs.
    // Bases, counter and error are loaded on the edge into LAUNCH so they
    // are already valid while npu_start is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            acquire_q <= 1'b0;
            err_q     <= 1'b0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_c_q  <= '0;
            cnt       <= '0;
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_ok) begin
                        state    <= LAUNCH;
                        start_q  <= 1'b1;
                        base_a_q <= bus.matA;
                        base_b_q <= bus.matB;
                        base_c_q <= bus.matC;
                        cnt      <= '0;
                        err_q    <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state <= RUN;
                    cnt   <= '0;
                end
                RUN: begin
                    if (bus.npu_done) begin
                        state     <= ACK;
                        acquire_q <= 1'b1;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= ACK;
                        acquire_q <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (!bus.EN_NPU) begin
                        state     <= IDLE;
                        acquire_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.R_DATA      = r_data_q;
    assign bus.npu_rd_data = npu_rd_data_q;
    assign bus.acquire_npu = acquire_q;
    assign bus.npu_start   = start_q;
    assign bus.npu_err     = err_q;
    assign bus.npu_base_a  = base_a_q;
    assign bus.npu_base_b  = base_b_q;
    assign bus.npu_base_c  = base_c_q;

endmodule

// File: tb/tb_npu_mem_responder.sv
// Directed + randomized bench for npu_mem_responder with a word-array
// reference model of the shared memory.
module tb_npu_mem_responder;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int DEP = 1024;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    npu_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    npu_mem_responder #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEP),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [DEP];
    int unsigned   wq[$];
    logic [DW-1:0] last_nrd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.memread_c   = 1'b0;
        bus.memwrite_c  = 1'b0;
        bus.addr_c      = '0;
        bus.wd_c        = '0;
        bus.EN_NPU      = 1'b0;
        bus.matA        = '0;
        bus.matB        = '0;
        bus.matC        = '0;
        bus.npu_done    = 1'b0;
        bus.npu_rd_en   = 1'b0;
        bus.npu_rd_addr = '0;
        bus.npu_wr_en   = 1'b0;
        bus.npu_wr_addr = '0;
        bus.npu_wr_data = '0;
    endtask

    function automatic logic [DW-1:0] exp_cpu(input logic [31:0] a);
        if (a[31:AW+2] != 0) return '0;
        return model[a[AW+1:2]];
    endfunction

    task automatic cpu_write(input logic [31:0] a, input logic [DW-1:0] d);
        bus.memwrite_c = 1'b1;
        bus.addr_c     = a;
        bus.wd_c       = d;
        @(negedge clk);
        chk("wr_haz", bus.mem_haz, 0);
        tick();
        bus.memwrite_c = 1'b0;
        if (a[31:AW+2] == 0) begin
            model[a[AW+1:2]] = d;
            wq.push_back(int'(a[AW+1:2]));
        end
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [DW-1:0] e);
        bus.memread_c = 1'b1;
        bus.addr_c    = a;
        @(negedge clk);
        chk("rd_haz_phase1", bus.mem_haz, 1);
        tick();
        @(negedge clk);
        chk("rd_haz_phase2", bus.mem_haz, 0);
        tick();
        chk("rd_data", bus.R_DATA, e);
        bus.memread_c = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned idx;
        int unsigned ra;
        int unsigned wa;
        logic [31:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        int n;

        idle_bus();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", bus.R_DATA, 0);
        chk("rst_haz", bus.mem_haz, 0);
        chk("rst_acq", bus.acquire_npu, 0);
        chk("rst_start", bus.npu_start, 0);
        chk("rst_err", bus.npu_err, 0);
        chk("rst_base_a", bus.npu_base_a, 0);
        chk("rst_nrd", bus.npu_rd_data, 0);
        rst = 1'b1;
        tick();

        // store then load
        cpu_write(32'h40, 32'hDEAD_BEEF);
        cpu_read(32'h40, 32'hDEAD_BEEF);
        cpu_write(32'h44, 32'h4444_4444);

        // random stores, then loads of stored words
        for (int i = 0; i < 16; i++) begin
            idx = $urandom_range(32'h40, DEP - 1);
            a = {20'h0, idx[AW-1:0], 2'($urandom)};
            cpu_write(a, $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            idx = wq[$urandom_range(0, wq.size() - 1)];
            a = {20'h0, idx[AW-1:0], 2'($urandom)};
            cpu_read(a, exp_cpu(a));
        end

        // out-of-range: store dropped, load returns zero
        cpu_write(32'h1000_0040, 32'hBAD0_BAD0);
        cpu_read(32'h40, 32'hDEAD_BEEF);
        cpu_read(32'h1000_0000, 32'h0);

        // simultaneous load+store: store wins, no hazard, R_DATA untouched
        bus.memread_c  = 1'b1;
        bus.memwrite_c = 1'b1;
        bus.addr_c     = 32'h80;
        bus.wd_c       = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rw_haz", bus.mem_haz, 0);
        tick();
        chk("rw_rdata_hold", bus.R_DATA, 0);
        bus.memread_c  = 1'b0;
        bus.memwrite_c = 1'b0;
        model[32] = 32'hCAFE_F00D;
        cpu_read(32'h80, 32'hCAFE_F00D);

        // load re-targeted in phase 2 restarts
        bus.memread_c = 1'b1;
        bus.addr_c    = 32'h80;
        @(negedge clk);
        chk("rs_haz1", bus.mem_haz, 1);
        tick();
        bus.addr_c = 32'h40;
        @(negedge clk);
        chk("rs_haz_restart", bus.mem_haz, 1);
        tick();
        chk("rs_rdata_hold", bus.R_DATA, 32'hCAFE_F00D);
        @(negedge clk);
        chk("rs_haz2", bus.mem_haz, 0);
        tick();
        chk("rs_rdata", bus.R_DATA, 32'hDEAD_BEEF);
        bus.memread_c = 1'b0;

        // launch
        bus.matA   = 10'h010;
        bus.matB   = 10'h020;
        bus.matC   = 10'h030;
        bus.EN_NPU = 1'b1;
        tick();
        chk("launch_start", bus.npu_start, 1);
        chk("launch_base_a", bus.npu_base_a, 10'h010);
        chk("launch_base_b", bus.npu_base_b, 10'h020);
        chk("launch_base_c", bus.npu_base_c, 10'h030);
        bus.matA      = 10'h3FF;
        bus.memread_c = 1'b1;
        bus.addr_c    = 32'h40;
        tick();
        chk("run_start_low", bus.npu_start, 0);
        chk("run_base_held", bus.npu_base_a, 10'h010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("run_rd_haz", bus.mem_haz, 1);
            tick();
        end
        bus.memread_c  = 1'b0;
        bus.memwrite_c = 1'b1;
        bus.addr_c     = 32'h44;
        bus.wd_c       = 32'h7777_7777;
        @(negedge clk);
        chk("run_wr_haz", bus.mem_haz, 1);
        tick();
        bus.memwrite_c = 1'b0;

        bus.npu_wr_en   = 1'b1;
        bus.npu_wr_addr = 10'h030;
        bus.npu_wr_data = 32'h1234;
        tick();
        bus.npu_wr_en = 1'b0;
        model[10'h030] = 32'h1234;

        for (int i = 0; i < 5; i++) begin
            ra = (i == 0) ? 32'h30 : wq[$urandom_range(0, wq.size() - 1)];
            wa = (i == 0) ? 32'h30 : $urandom_range(32'h100, DEP - 1);
            d  = $urandom;
            e  = model[ra];
            bus.npu_rd_en   = 1'b1;
            bus.npu_rd_addr = ra[AW-1:0];
            bus.npu_wr_en   = 1'b1;
            bus.npu_wr_addr = wa[AW-1:0];
            bus.npu_wr_data = (i == 0) ? 32'h1234 : d;
            tick();
            chk("npu_rd_data", bus.npu_rd_data, e);
            last_nrd = e;
            if (i != 0) begin
                model[wa] = d;
                wq.push_back(wa);
            end
        end
        bus.npu_rd_en = 1'b0;
        bus.npu_wr_en = 1'b0;

        bus.npu_done = 1'b1;
        tick();
        bus.npu_done = 1'b0;
        chk("done_acq", bus.acquire_npu, 1);
        chk("done_err", bus.npu_err, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ack_hold", bus.acquire_npu, 1);
        end
        bus.EN_NPU = 1'b0;
        tick();
        chk("ack_exit", bus.acquire_npu, 0);

        // NPU activity outside RUN is ignored
        bus.npu_done    = 1'b1;
        bus.npu_wr_en   = 1'b1;
        bus.npu_wr_addr = 10'h030;
        bus.npu_wr_data = 32'h5555;
        bus.npu_rd_en   = 1'b1;
        bus.npu_rd_addr = 10'h010;
        tick();
        idle_bus();
        chk("idle_done_acq", bus.acquire_npu, 0);
        chk("idle_start", bus.npu_start, 0);
        chk("idle_nrd_hold", bus.npu_rd_data, last_nrd);
        cpu_read(32'hC0, 32'h1234);
        cpu_read(32'h44, 32'h4444_4444);

        // watchdog timeout, EN_NPU dropped during RUN
        bus.matA   = 10'h100;
        bus.matB   = 10'h200;
        bus.matC   = 10'h300;
        bus.EN_NPU = 1'b1;
        tick();
        chk("to_start", bus.npu_start, 1);
        tick();
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) bus.EN_NPU = 1'b0;
            tick();
            if (bus.acquire_npu === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("to_cycles", n, TO);
        chk("to_err", bus.npu_err, 1);
        tick();
        chk("to_min_ack", bus.acquire_npu, 0);
        chk("to_err_held", bus.npu_err, 1);

        // next launch clears the error
        bus.EN_NPU = 1'b1;
        tick();
        chk("relaunch_start", bus.npu_start, 1);
        chk("relaunch_err", bus.npu_err, 0);
        tick();
        bus.npu_done = 1'b1;
        tick();
        bus.npu_done = 1'b0;
        chk("relaunch_acq", bus.acquire_npu, 1);
        chk("relaunch_err2", bus.npu_err, 0);
        bus.EN_NPU = 1'b0;
        tick();
        chk("relaunch_exit", bus.acquire_npu, 0);

        // asynchronous reset mid-RUN
        bus.matA   = 10'h155;
        bus.EN_NPU = 1'b1;
        tick();
        tick();
        bus.npu_rd_en   = 1'b1;
        bus.npu_rd_addr = 10'h030;
        tick();
        bus.npu_rd_en = 1'b0;
        chk("mr_nrd", bus.npu_rd_data, 32'h1234);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_start", bus.npu_start, 0);
        chk("mr_base_a", bus.npu_base_a, 0);
        chk("mr_nrd0", bus.npu_rd_data, 0);
        chk("mr_rdata0", bus.R_DATA, 0);
        chk("mr_acq", bus.acquire_npu, 0);
        chk("mr_err", bus.npu_err, 0);
        chk("mr_haz", bus.mem_haz, 0);
        bus.EN_NPU = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_start", bus.npu_start, 0);
        end
        cpu_read(32'hC0, 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npu_mem_responder.md
Name: npu_mem_responder

Overview:
- Memory-side responder for the CPU data-memory interface (memread_c, memwrite_c, addr_c, wd_c, R_DATA, mem_haz) and the CPU→NPU handshake (EN_NPU, matA/B/C, acquire_npu).
- Owns a single DEPTH×DATA_W data array shared by CPU and NPU engine.
- Arbitrates array ownership: CPU in IDLE/ACK, NPU in LAUNCH/RUN.
- Sequences NPU launch and completion, with a watchdog timeout.

Parameters:
- ADDR_W, 10, word-address width; matches matA/matB/matC width.
- DATA_W, 32, data word width.
- DEPTH, 1024, array words; must equal 2**ADDR_W.
- TIMEOUT, 4096, maximum RUN cycles before forced completion.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- memread_c  in  1  CPU load request.
- memwrite_c  in  1  CPU store request.
- addr_c  in  32  CPU byte address; word index = addr_c[ADDR_W+1:2].
- wd_c  in  DATA_W  CPU store data.
- R_DATA  out  DATA_W  CPU load data, registered.
- mem_haz  out  1  CPU must hold the request and stall.
- EN_NPU  in  1  CPU requests NPU operation (level).
- matA, matB, matC  in  ADDR_W  word base addresses of operands A, B and result C.
- acquire_npu  out  1  NPU operation finished, held until EN_NPU falls.
- npu_start  out  1  one-cycle launch pulse to the NPU engine.
- npu_base_a, npu_base_b, npu_base_c  out  ADDR_W  bases latched at launch.
- npu_rd_en  in  1  NPU read request.
- npu_rd_addr  in  ADDR_W  NPU read word address.
- npu_rd_data  out  DATA_W  NPU read data.
- npu_wr_en  in  1  NPU write enable.
- npu_wr_addr  in  ADDR_W  NPU write word address.
- npu_wr_data  in  DATA_W  NPU write data.
- npu_done  in  1  NPU completion pulse.
- npu_err  out  1  last operation ended by timeout.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rd_phase=0; all outputs 0; timeout counter 0. Array contents are not reset.
- Array:
  - One synchronous read port, one write port.
  - The read port is muxed by owner: CPU in IDLE/ACK, NPU otherwise.
  - Read during write to the same address returns the old data.
- FSM states: IDLE, LAUNCH, RUN, ACK.
- IDLE → LAUNCH: EN_NPU=1 and rd_phase=0 and memwrite_c=0. Otherwise launch is deferred cycle by cycle.
- LAUNCH, one cycle:
  - npu_start=1.
  - Latch matA/B/C into npu_base_a/b/c.
  - Clear counter and npu_err.
  - Next state RUN.
- RUN: counter increments each cycle.
  - npu_done=1 → ACK.
  - Counter reaches TIMEOUT−1 without npu_done → ACK and npu_err<=1.
- ACK: acquire_npu=1. Exit to IDLE in the cycle after EN_NPU is seen 0 (minimum one ACK cycle, even if EN_NPU already fell during RUN).
- npu_done outside RUN is ignored. NPU rd/wr outside LAUNCH/RUN is ignored; npu_rd_data holds its value.
- NPU reads: npu_rd_data is valid one cycle after npu_rd_en. A read and a write may occur in the same cycle.
- CPU write (IDLE/ACK): committed at the edge; mem_haz=0; R_DATA unchanged.
- CPU read (IDLE/ACK), two-phase:
  - Cycle 1 (rd_phase=0): mem_haz=1, address latched, rd_phase<=1.
  - Cycle 2 (request still present, same word index): R_DATA updates at the end of the cycle; mem_haz=0; rd_phase<=0.
  - Request dropped or word index changed in cycle 2: discard and restart at cycle 1.
- memread_c and memwrite_c both 1: the write executes and the read is ignored, with no hazard.
- Address out of range (addr_c[31:ADDR_W+2]≠0): writes are dropped; reads complete with R_DATA=0. addr_c[1:0] is ignored.
- CPU request during LAUNCH/RUN: mem_haz=1 combinationally; no array effect; rd_phase is forced to 0.
- Reset mid-RUN: immediate return to IDLE. The NPU engine sees no further npu_start until a new launch.

Test Plan:
- Store then load: write 0xDEADBEEF to addr 0x40, then read 0x40 → mem_haz=1 for 1 cycle; R_DATA=0xDEADBEEF after the second cycle.
- Launch: EN_NPU=1 with matA=0x010, matB=0x020, matC=0x030 → npu_start pulses exactly 1 cycle; bases latched to those values.
- NPU path: NPU writes 0x1234 at 0x030, pulses npu_done → acquire_npu=1 and held while EN_NPU=1. EN_NPU drops → IDLE; CPU read of addr 0xC0 returns 0x1234.
- Hazard: CPU load issued during RUN → mem_haz=1 every cycle until ACK; array unchanged.
- Timeout: TIMEOUT=16, no npu_done → ACK entered 16 cycles after RUN entry; npu_err=1; the next launch clears npu_err.
- Edge cases:
  - rst pulse low mid-RUN → all outputs 0 asynchronously.
  - Out-of-range read (addr_c=0x1000_0000) → R_DATA=0.
  - Simultaneous read+write → write wins, mem_haz=0.
